vga_dac_out: RTL
================

// Module: vga_dac_out
// PURPOSE
//  Pixel back end downstream of the 640x400 timing generator (vgaGen).
//  - Fetches one 8-bit mode-13h pixel per clock from VRAM at the generator's 320x200 address.
//  - Maps each pixel through a 256-entry, 18-bit (6:6:6) palette loaded over a VGA-DAC-style CPU write port.
//  - Drives RGB, HSync and VSync pins, with sync and blank re-aligned to the colour pipeline.
// PARAMETERS
//  OUT_BITS    4  bits per colour channel at the pins, 1..6; takes the MSBs of the 6-bit DAC value
//  HSYNC_IDLE  1  oHSync value while in reset (inactive level)
//  VSYNC_IDLE  0  oVSync value while in reset (inactive level)
// PORTS
//  iClk        in   1         pixel clock, 25.175 MHz
//  iRst        in   1         reset, asynchronous, active-high
//  iAddr       in   16        pixel byte address from the timing generator
//  iBlank      in   1         blanking flag from the timing generator
//  iHSync      in   1         horizontal sync from the timing generator
//  iVSync      in   1         vertical sync from the timing generator
//  oVramAddr   out  16        VRAM read address
//  iVramData   in   8         VRAM read data; valid one clock after oVramAddr changes
//  iDacWrIdx   in   1         CPU write strobe for the DAC write-index register (port 3C8h)
//  iDacWrData  in   1         CPU write strobe for the DAC data register (port 3C9h)
//  iDacData    in   8         CPU write data; only bits [5:0] are used by the data register
//  oRed        out  OUT_BITS  red
//  oGreen      out  OUT_BITS  green
//  oBlue       out  OUT_BITS  blue
//  oHSync      out  1         delayed horizontal sync
//  oVSync      out  1         delayed vertical sync
//  oBlank      out  1         delayed blank
// BEHAVIOUR
//  Reset (async, takes effect immediately):
//   - oRed/oGreen/oBlue = 0, oBlank = 1, oHSync = HSYNC_IDLE, oVSync = VSYNC_IDLE, oVramAddr = 0.
//   - All pipeline stages are loaded with these same values.
//   - DAC index = 0, DAC phase = R. Palette contents are not reset.
//  Video pipeline: 5 registered stages, no stalls.
//   - Edge 1: oVramAddr <= iAddr.
//   - Edge 3: palette read address <= iVramData.
//   - Edge 4: palette data registered.
//   - Edge 5: output registers loaded.
//   - iBlank/iHSync/iVSync pass through a 5-deep shift register, so outputs sampled at edge n reflect the inputs sampled at edge n-5.
//   - When the delayed blank is 1, RGB is forced to 0. Otherwise each channel = entry[ch][5:6-OUT_BITS].
//  DAC write FSM (phase R -> G -> B -> R):
//   - iDacWrIdx: index <= iDacData, phase <= R, and any partial R/G triple is discarded.
//   - iDacWrData in phase R or G: latch iDacData[5:0] into the staging register, then advance phase.
//   - iDacWrData in phase B: write {R,G,B} to palette[index], index <= index+1 (8-bit wrap, FFh -> 00h), phase <= R.
//   - iDacWrIdx and iDacWrData in the same clock: the index write wins and the data write is dropped.
//   - Palette write and video read hitting the same entry in the same clock: the colour for that one pixel is
//     undefined; there is no other effect. Writes are allowed at any time, including active display.
//  A reset during a DAC triple discards the triple. A reset mid-frame restarts the pipeline; the first
//  5 clocks after release show blanked output.
// STRUCTURE
//  - Shared video package: DAC_BITS = 6, PAL_ENTRIES = 256, PAL_W = 18, VIDEO_LATENCY = 5. The timing
//    generator and any sync consumers use VIDEO_LATENCY.
//  - Sub-module vga_palette_ram: 256 x 18 simple dual-port RAM with one write port and one registered
//    read port; maps to iCE40 BRAM.
//  - The DAC FSM, the sync/blank delay line and the output mux stay in this module.
// TESTING
//  1. Reset mid-frame while driving active pixels -> outputs go to 0/0/0, blank 1, HSync 1, VSync 0
//     with no clock; 5 clocks after release outputs follow the inputs again.
//  2. Write idx 10h, then data 3Fh,00h,2Ah -> palette[10h] = {3F,00,2A}; the next triple lands in 11h.
//  3. VRAM model returns 10h at 0140h; drive iAddr = 0140h, iBlank = 0 -> exactly 5 clocks later
//     R = Fh, G = 0h, B = Ah; oVramAddr = 0140h after 1 clock.
//  4. Same as 3 with iBlank = 1 -> RGB = 0, oBlank = 1 at the same cycle.
//  5. Write idx FFh, then six data writes -> entries FFh and 00h are both written; index ends at 01h.
//  6. Write idx 05h, data R and G, then idx 05h again (the second time in the same clock as a data
//     write) -> palette[05h] unchanged, phase = R. Run a random sync pattern and check a fixed 5-clock
//     alignment of sync/blank against RGB across 2 full frames.

Source files
------------

// File: rtl/vga_dac_out_pkg.sv
// -----------------------------------------------------------------------------
// vga_dac_out_pkg
// Shared video constants and types for the pixel back end. The timing
// generator and any sync consumers use VIDEO_LATENCY so that they agree with
// the depth of the colour pipeline.
// -----------------------------------------------------------------------------
package vga_dac_out_pkg;

    localparam int DAC_BITS      = 6;    // bits per colour channel in the DAC
    localparam int PAL_ENTRIES   = 256;  // palette depth
    localparam int PAL_W         = 18;   // palette word {R,G,B}, 6 bits each
    localparam int PAL_AW        = 8;    // palette address width
    localparam int VIDEO_LATENCY = 5;    // clocks from iAddr/iBlank/iSync to pins

    // Position inside a DAC data triple.
    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } dac_phase_t;

    // Pack three DAC channels into one palette word, red in the MSBs.
    function automatic logic [PAL_W-1:0] pal_pack(
        input logic [DAC_BITS-1:0] red,
        input logic [DAC_BITS-1:0] green,
        input logic [DAC_BITS-1:0] blue
    );
        return {red, green, blue};
    endfunction

endpackage

// File: rtl/vga_dac_out_if.sv
// -----------------------------------------------------------------------------
// vga_dac_out_if
// Bundles every non-clock signal of the pixel back end:
//   timing generator side : iAddr, iBlank, iHSync, iVSync
//   VRAM side             : oVramAddr (to VRAM), iVramData (from VRAM)
//   CPU DAC port          : iDacWrIdx (3C8h strobe), iDacWrData (3C9h strobe), iDacData
//   pins                  : oRed, oGreen, oBlue, oHSync, oVSync, oBlank
// slave  : the vga_dac_out block itself.
// master : whatever drives the block (system top level or testbench).
// -----------------------------------------------------------------------------
interface vga_dac_out_if #(
    parameter int OUT_BITS = 4
);
    logic [15:0]         iAddr;
    logic                iBlank;
    logic                iHSync;
    logic                iVSync;
    logic [15:0]         oVramAddr;
    logic [7:0]          iVramData;
    logic                iDacWrIdx;
    logic                iDacWrData;
    logic [7:0]          iDacData;
    logic [OUT_BITS-1:0] oRed;
    logic [OUT_BITS-1:0] oGreen;
    logic [OUT_BITS-1:0] oBlue;
    logic                oHSync;
    logic                oVSync;
    logic                oBlank;

    modport slave (
        input  iAddr, iBlank, iHSync, iVSync, iVramData,
        input  iDacWrIdx, iDacWrData, iDacData,
        output oVramAddr, oRed, oGreen, oBlue, oHSync, oVSync, oBlank
    );

    modport master (
        output iAddr, iBlank, iHSync, iVSync, iVramData,
        output iDacWrIdx, iDacWrData, iDacData,
        input  oVramAddr, oRed, oGreen, oBlue, oHSync, oVSync, oBlank
    );

endinterface

// File: rtl/vga_palette_ram.sv
// -----------------------------------------------------------------------------
// vga_palette_ram
// 256 x 18 simple dual-port RAM: one write port, one read port with a
// registered output. Written so that it maps onto a single block RAM.
// Ports:
//   iClk     in  1       clock
//   iWe      in  1       write enable
//   iWrAddr  in  8       write address
//   iWrData  in  18      write data {R,G,B}
//   iRdAddr  in  8       read address
//   oRdData  out 18      read data, one clock after iRdAddr
// A write and read of the same entry in the same clock returns the old word;
// callers treat that pixel's colour as don't-care.
// -----------------------------------------------------------------------------
module vga_palette_ram
    import vga_dac_out_pkg::*;
(
    input  logic              iClk,
    input  logic              iWe,
    input  logic [PAL_AW-1:0] iWrAddr,
    input  logic [PAL_W-1:0]  iWrData,
    input  logic [PAL_AW-1:0] iRdAddr,
    output logic [PAL_W-1:0]  oRdData
);

    logic [PAL_W-1:0] r_mem [0:PAL_ENTRIES-1];
    logic [PAL_W-1:0] r_rd_data;

    // No reset here: block RAM contents and its output register are left alone.
    always_ff @(posedge iClk) begin
        if (iWe) begin
            r_mem[iWrAddr] <= iWrData;
        end
        r_rd_data <= r_mem[iRdAddr];
    end

    assign oRdData = r_rd_data;

endmodule

// File: rtl/vga_dac_out.sv
// -----------------------------------------------------------------------------
// vga_dac_out
// Pixel back end behind the 640x400 timing generator. Fetches one mode-13h
// byte per clock from VRAM, maps it through the 256 x 18 palette and drives
// the RGB and sync pins with sync/blank re-aligned to the colour pipeline.
// Parameters:
//   OUT_BITS    1..6  pin bits per channel (MSBs of the 6-bit DAC value)
//   HSYNC_IDLE        oHSync level while in reset
//   VSYNC_IDLE        oVSync level while in reset
// Ports:
//   iClk  in  1   pixel clock
//   iRst  in  1   asynchronous active-high reset
//   bus   slave   vga_dac_out_if (timing, VRAM, CPU DAC port, pins)
// Pipeline (edge numbers relative to iAddr being sampled):
//   1: oVramAddr   2: VRAM data   3: palette address   4: palette data
//   5: pins. Sync/blank go through a VIDEO_LATENCY-deep shift register.
// -----------------------------------------------------------------------------
module vga_dac_out
    import vga_dac_out_pkg::*;
#(
    parameter int   OUT_BITS   = 4,
    parameter logic HSYNC_IDLE = 1'b1,
    parameter logic VSYNC_IDLE = 1'b0
) (
    input  logic          iClk,
    input  logic          iRst,
    vga_dac_out_if.slave  bus
);

    // ---------------------------------------------------------------- video
    logic [15:0]              r_vram_addr;
    logic [PAL_AW-1:0]        r_pal_addr;
    logic [PAL_W-1:0]         w_pal_data;
    logic [VIDEO_LATENCY-1:0] r_blank_dly;
    logic [VIDEO_LATENCY-1:0] r_hs_dly;
    logic [VIDEO_LATENCY-1:0] r_vs_dly;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_vram_addr <= '0;
            r_pal_addr  <= '0;
            r_blank_dly <= '1;
            r_hs_dly    <= {VIDEO_LATENCY{HSYNC_IDLE}};
            r_vs_dly    <= {VIDEO_LATENCY{VSYNC_IDLE}};
        end else begin
            r_vram_addr <= bus.iAddr;
            r_pal_addr  <= bus.iVramData;
            r_blank_dly <= {r_blank_dly[VIDEO_LATENCY-2:0], bus.iBlank};
            r_hs_dly    <= {r_hs_dly[VIDEO_LATENCY-2:0],    bus.iHSync};
            r_vs_dly    <= {r_vs_dly[VIDEO_LATENCY-2:0],    bus.iVSync};
        end
    end

    // Channel gi: 0 = blue, 1 = green, 2 = red. The blank used here is one
    // stage short of the pin so that it lines up with the palette output and
    // lands on the pins in the same clock as oBlank.
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        logic [OUT_BITS-1:0] r_chan;

        always_ff @(posedge iClk or posedge iRst) begin
            if (iRst) begin
                r_chan <= '0;
            end else if (r_blank_dly[VIDEO_LATENCY-2]) begin
                r_chan <= '0;
            end else begin
                r_chan <= w_pal_data[(gi+1)*DAC_BITS-1 -: OUT_BITS];
            end
        end
    end

    assign bus.oVramAddr = r_vram_addr;
    assign bus.oBlue     = g_chan[0].r_chan;
    assign bus.oGreen    = g_chan[1].r_chan;
    assign bus.oRed      = g_chan[2].r_chan;
    assign bus.oBlank    = r_blank_dly[VIDEO_LATENCY-1];
    assign bus.oHSync    = r_hs_dly[VIDEO_LATENCY-1];
    assign bus.oVSync    = r_vs_dly[VIDEO_LATENCY-1];

    // Low DAC bits below OUT_BITS never reach the pins.
    logic w_unused;
    assign w_unused = &{1'b0, w_pal_data};

    // ------------------------------------------------------------ DAC port
    dac_phase_t          r_phase;
    dac_phase_t          w_phase_next;
    logic [PAL_AW-1:0]   r_index;
    logic [PAL_AW-1:0]   w_index_next;
    logic [DAC_BITS-1:0] r_stage_r;
    logic [DAC_BITS-1:0] w_stage_r_next;
    logic [DAC_BITS-1:0] r_stage_g;
    logic [DAC_BITS-1:0] w_stage_g_next;
    logic                w_pal_we;
    logic [PAL_W-1:0]    w_pal_wdata;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_phase   <= PH_R;
            r_index   <= '0;
            r_stage_r <= '0;
            r_stage_g <= '0;
        end else begin
            r_phase   <= w_phase_next;
            r_index   <= w_index_next;
            r_stage_r <= w_stage_r_next;
            r_stage_g <= w_stage_g_next;
        end
    end

    always_comb begin
        w_phase_next   = r_phase;
        w_index_next   = r_index;
        w_stage_r_next = r_stage_r;
        w_stage_g_next = r_stage_g;
        w_pal_we       = 1'b0;
        w_pal_wdata    = pal_pack(r_stage_r, r_stage_g, bus.iDacData[DAC_BITS-1:0]);

        // Index write has priority; a simultaneous data strobe is dropped and
        // any half-entered triple is abandoned by returning to R.
        if (bus.iDacWrIdx) begin
            w_index_next = bus.iDacData;
            w_phase_next = PH_R;
        end else if (bus.iDacWrData) begin
            unique case (r_phase)
                PH_R: begin
                    w_stage_r_next = bus.iDacData[DAC_BITS-1:0];
                    w_phase_next   = PH_G;
                end
                PH_G: begin
                    w_stage_g_next = bus.iDacData[DAC_BITS-1:0];
                    w_phase_next   = PH_B;
                end
                PH_B: begin
                    w_pal_we     = 1'b1;
                    w_index_next = r_index + 1'b1;   // wraps FFh -> 00h
                    w_phase_next = PH_R;
                end
                default: w_phase_next = PH_R;
            endcase
        end
    end

    vga_palette_ram u_palette (
        .iClk    (iClk),
        .iWe     (w_pal_we),
        .iWrAddr (r_index),
        .iWrData (w_pal_wdata),
        .iRdAddr (r_pal_addr),
        .oRdData (w_pal_data)
    );

endmodule
